h_bridge_guard: RTL and testbench

Per-channel output stage that sits directly downstream of each pwm_channel. It consumes the raw PWM signal and a requested drive mode and produces the final pwm_out, H_bridge_1 and H_bridge_2 pin signals. It guarantees that the two bridge legs are never switched between drive modes without a programmable all-off dead time. An overcurrent fault latches all outputs off until the fault is explicitly cleared. One instance is placed per PWM channel, between the pwm_channel and the top-level pins.

---
 rtl/h_bridge_guard.sv | 125 ++++++++++++
 tb/tb_h_bridge_guard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/h_bridge_guard.sv
// h_bridge_guard: per-channel output stage between a pwm_channel and the pins.
// Drives pwm_out / H_bridge_1 / H_bridge_2 from a requested mode. It inserts an
// all-off dead time whenever the bridge passes between two driving modes, and it
// latches every output off on overcurrent until the fault is explicitly cleared.
module h_bridge_guard #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [1:0]          mode_in,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                fault_in,
  input  logic                fault_clear,
  output logic                pwm_out,
  output logic                H_bridge_1,
  output logic                H_bridge_2,
  output logic                dead_active,
  output logic                fault_latched
);

  typedef enum logic [2:0] {
    S_COAST = 3'd0,
    S_FWD   = 3'd1,
    S_REV   = 3'd2,
    S_BRAKE = 3'd3,
    S_DEAD  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t              state, state_next;
  logic [DT_WIDTH-1:0] dead_cnt, dead_cnt_next;
  logic [1:0]          target_mode;
  state_t              target_state;
  logic [DT_WIDTH-1:0] dead_load;

  // Map a 2-bit mode request onto the matching steady state.
  function automatic state_t mode_to_state(input logic [1:0] m);
    case (m)
      2'b01:   return S_FWD;
      2'b10:   return S_REV;
      2'b11:   return S_BRAKE;
      default: return S_COAST;
    endcase
  endfunction

  // Disabled channels always aim for COAST; a zero dead time is stretched to one cycle.
  always_comb begin
    target_mode  = enable ? mode_in : 2'b00;
    target_state = mode_to_state(target_mode);
    dead_load    = (deadtime == '0) ? DT_WIDTH'(1) : deadtime;
  end

  // Next-state and dead-counter logic; fault has the highest priority everywhere.
  always_comb begin
    state_next    = state;
    dead_cnt_next = dead_cnt;
    if (fault_in) begin
      state_next    = S_FAULT;
      dead_cnt_next = '0;
    end else begin
      case (state)
        S_FAULT: begin
          if (fault_clear) begin
            state_next = S_COAST;
          end
        end
        S_COAST: begin
          state_next = target_state;
        end
        S_FWD, S_REV, S_BRAKE: begin
          if (target_state == S_COAST) begin
            state_next = S_COAST;
          end else if (target_state != state) begin
            state_next    = S_DEAD;
            dead_cnt_next = dead_load;
          end
        end
        S_DEAD: begin
          if (dead_cnt <= DT_WIDTH'(1)) begin
            state_next    = target_state;
            dead_cnt_next = '0;
          end else begin
            dead_cnt_next = dead_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state_next    = S_COAST;
          dead_cnt_next = '0;
        end
      endcase
    end
  end

  // State and dead-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_COAST;
      dead_cnt <= '0;
    end else begin
      state    <= state_next;
      dead_cnt <= dead_cnt_next;
    end
  end

  // Pin registers decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out       <= 1'b0;
      H_bridge_1    <= 1'b0;
      H_bridge_2    <= 1'b0;
      dead_active   <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      pwm_out       <= ((state_next == S_FWD) || (state_next == S_REV)) ? pwm_in
                       : (state_next == S_BRAKE);
      H_bridge_1    <= (state_next == S_FWD);
      H_bridge_2    <= (state_next == S_REV);
      dead_active   <= (state_next == S_DEAD);
      fault_latched <= (state_next == S_FAULT);
    end
  end

endmodule

// File: tb/tb_h_bridge_guard.sv
// Testbench for h_bridge_guard: a directed vector table plus hand-written
// sequences for dead time, mid-dead enable drop, reset recovery and a random soak.
module tb_h_bridge_guard;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pwm_in;
  logic [1:0] mode_in;
  logic [7:0] deadtime;
  logic       fault_in;
  logic       fault_clear;
  logic       pwm_out;
  logic       H_bridge_1;
  logic       H_bridge_2;
  logic       dead_active;
  logic       fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  // Output bundle order: {pwm_out, H_bridge_1, H_bridge_2, dead_active, fault_latched}
  localparam logic [4:0] O_ZERO  = 5'b00000;
  localparam logic [4:0] O_DEAD  = 5'b00010;
  localparam logic [4:0] O_FAULT = 5'b00001;
  localparam logic [4:0] O_BRAKE = 5'b10000;

  typedef struct {
    logic       rst;
    logic       en;
    logic       pwm;
    logic [1:0] mode;
    logic [7:0] dt;
    logic       flt;
    logic       clr;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[22];

  h_bridge_guard #(.DT_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .mode_in       (mode_in),
    .deadtime      (deadtime),
    .fault_in      (fault_in),
    .fault_clear   (fault_clear),
    .pwm_out       (pwm_out),
    .H_bridge_1    (H_bridge_1),
    .H_bridge_2    (H_bridge_2),
    .dead_active   (dead_active),
    .fault_latched (fault_latched)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {pwm_out, H_bridge_1, H_bridge_2, dead_active, fault_latched};
  endfunction

  // Drive one set of inputs, take one clock edge, then settle 1 ns past the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic pwm,
                               input logic [1:0] mode, input logic [7:0] dt,
                               input logic flt, input logic clr);
    reset       = rst;
    enable      = en;
    pwm_in      = pwm;
    mode_in     = mode;
    deadtime    = dt;
    fault_in    = flt;
    fault_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int good;
    int h2_seen;
    int both_high;
    int illegal_edge;
    logic p;
    logic [4:0] prev;
    logic [4:0] cur;

    reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; mode_in = 2'b00;
    deadtime = 8'd0; fault_in = 1'b0; fault_clear = 1'b0;
    #2;

    //            rst  en   pwm  mode   dt     flt  clr  expected
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, O_ZERO};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 5'b11000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 8'd0, 1'b0, 1'b0, 5'b01000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 5'b11000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 8'd0, 1'b0, 1'b0, O_ZERO};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 5'b10100};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b10, 8'd0, 1'b0, 1'b0, 5'b00100};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b10, 8'd0, 1'b0, 1'b0, O_ZERO};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, O_BRAKE};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, O_ZERO};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b1, 5'b11000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b1, 1'b0, O_FAULT};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b0, O_FAULT};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b1, 1'b1, O_FAULT};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b1, O_ZERO};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 2'b01, 8'd0, 1'b0, 1'b0, 5'b01000};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 2'b10, 8'd2, 1'b0, 1'b0, O_DEAD};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'b10, 8'd2, 1'b0, 1'b0, O_DEAD};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'd2, 1'b0, 1'b0, 5'b10100};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, O_DEAD};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, O_BRAKE};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, O_ZERO};

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].pwm, vecs[i].mode,
                    vecs[i].dt, vecs[i].flt, vecs[i].clr);
      checkOutput($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // FWD -> REV with a 50-cycle dead time.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'd50, 1'b0, 1'b0);
    checkOutput("dt50_fwd", 32'(outs()), 32'(5'b01000));
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'd50, 1'b0, 1'b0);
    good = 0;
    for (int i = 0; i < 50; i++) begin
      if (outs() == O_DEAD) good++;
      p = 1'(i);
      applyStimulus(1'b0, 1'b1, p, 2'b10, 8'd50, 1'b0, 1'b0);
    end
    checkOutput("dt50_dead_cycles", 32'(good), 32'd50);
    checkOutput("dt50_rev_entry", 32'(outs()), 32'(5'b10100));
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'd50, 1'b0, 1'b0);
    checkOutput("dt50_rev_pwm", 32'(outs()), 32'(5'b00100));

    // FWD -> REV with dead time 20; enable drops after 10 dead cycles, deadtime edited mid-way.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'd20, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 8'd20, 1'b0, 1'b0);
    checkOutput("dt20_fwd", 32'(outs()), 32'(5'b11000));
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 8'd20, 1'b0, 1'b0);
    good = 0;
    h2_seen = 0;
    enable = 1'b1;
    deadtime = 8'd20;
    for (int i = 0; i < 20; i++) begin
      if (outs() == O_DEAD) good++;
      if (H_bridge_2) h2_seen++;
      if (i == 4) deadtime = 8'd3;
      if (i == 9) enable = 1'b0;
      applyStimulus(1'b0, enable, 1'b1, 2'b10, deadtime, 1'b0, 1'b0);
    end
    checkOutput("dt20_dead_cycles", 32'(good), 32'd20);
    checkOutput("dt20_coast_after", 32'(outs()), 32'(O_ZERO));
    for (int i = 0; i < 3; i++) begin
      if (H_bridge_2) h2_seen++;
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 8'd20, 1'b0, 1'b0);
    end
    checkOutput("dt20_h2_never_high", 32'(h2_seen), 32'd0);

    // Reset in the middle of DEAD.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'd10, 1'b0, 1'b0);
    checkOutput("rst_dead_pre", 32'(outs()), 32'(O_DEAD));
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 8'd10, 1'b0, 1'b0);
    checkOutput("rst_dead", 32'(outs()), 32'(O_ZERO));
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 8'd10, 1'b0, 1'b0);
    checkOutput("rst_dead_then_fwd", 32'(outs()), 32'(5'b11000));

    // Reset while in FAULT; the fault must not survive reset.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 8'd10, 1'b1, 1'b0);
    checkOutput("fault_enter", 32'(outs()), 32'(O_FAULT));
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 8'd10, 1'b0, 1'b0);
    checkOutput("rst_fault", 32'(outs()), 32'(O_ZERO));
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 8'd10, 1'b0, 1'b0);
    checkOutput("rst_fault_then_fwd", 32'(outs()), 32'(5'b11000));

    // Random soak: legs never both high, never a direct leg-to-leg swap.
    both_high = 0;
    illegal_edge = 0;
    prev = outs();
    for (int i = 0; i < 20000; i++) begin
      applyStimulus(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                    1'($urandom),
                    2'($urandom),
                    8'($urandom_range(0, 4)),
                    ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      cur = outs();
      if (cur[3] && cur[2]) both_high++;
      if ((prev[3] && cur[2]) || (prev[2] && cur[3])) illegal_edge++;
      if ((prev[3] || prev[2]) && (cur == O_BRAKE)) illegal_edge++;
      if ((prev == O_BRAKE) && (cur[3] || cur[2])) illegal_edge++;
      prev = cur;
    end
    checkOutput("soak_both_high", 32'(both_high), 32'd0);
    checkOutput("soak_illegal_edge", 32'(illegal_edge), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
